viterbi_link_ctrl: RTL and testbench

Sequencer and scoreboard for the convolutional encoder -> channel -> Viterbi decoder loopback.
- On start_i, sends N_BITS PRBS-7 bits into the encoder.
- Schedules one channel bit flip every INJ_PERIOD encoder symbols when injection is enabled.
- Gates the decoder enable and compares decoded bits against a DEC_LATENCY-deep delayed copy of the source.
- Reports good, bad and injected counts; replaces ad-hoc counters in the top-level link wrapper.

---
 rtl/viterbi_link_pkg.sv | 20 ++
 rtl/link_delay_line.sv | 42 ++++
 rtl/viterbi_link_ctrl.sv | 176 +++++++++++++++++
 tb/tb_viterbi_link_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_link_pkg.sv
// Shared types and constants for the Viterbi loopback link controller.
package viterbi_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] PRBS_SEED     = 7'h7F;
    // x^7 + x^6 + 1: feedback from register bits 6 and 5
    localparam logic [6:0] PRBS_TAPS     = 7'b110_0000;
    localparam logic [1:0] INJ_MASK_BIT0 = 2'b01;

    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS_TAPS)};
    endfunction

endpackage

// File: rtl/link_delay_line.sv
// Fixed-depth shift register of {tag, bit} pairs aligning source bits with decoder output.
module link_delay_line #(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic shift,
    input  logic tag_in,
    input  logic bit_in,
    output logic tag_out,
    output logic bit_out
);

    logic [DEPTH-1:0] tags;
    logic [DEPTH-1:0] bits;
    logic [DEPTH:0]   tags_ext;
    logic [DEPTH:0]   bits_ext;

    // Appending the input below the stored entries keeps DEPTH=1 legal.
    assign tags_ext = {tags, tag_in};
    assign bits_ext = {bits, bit_in};

    // NOTE: this storage is reset on purpose; a stale tag would be scored as a real compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags <= '0;
            bits <= '0;
        end else if (clear) begin
            tags <= '0;
            bits <= '0;
        end else if (shift) begin
            // NOTE: non-blocking assignment makes every stage take its neighbour's old value.
            tags <= tags_ext[DEPTH-1:0];
            bits <= bits_ext[DEPTH-1:0];
        end
    end

    assign tag_out = tags[DEPTH-1];
    assign bit_out = bits[DEPTH-1];

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Loopback sequencer: PRBS-7 source, periodic channel error injection and decoded-bit scoreboard.
module viterbi_link_ctrl
    import viterbi_link_pkg::*;
#(
    parameter int N_BITS      = 256,
    parameter int INJ_PERIOD  = 8,
    parameter int DEC_LATENCY = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             inj_en_i,
    output logic             enc_enable_o,
    output logic             enc_bit_o,
    input  logic             enc_valid_i,
    output logic [1:0]       inj_mask_o,
    output logic             dec_enable_o,
    input  logic             dec_bit_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o,
    output logic [CNT_W-1:0] inj_cnt_o
);

    localparam int RUN_W   = $clog2(N_BITS + 1);
    localparam int DRAIN_W = $clog2(DEC_LATENCY + 2);
    localparam int INJ_W   = $clog2(INJ_PERIOD);

    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(N_BITS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DEC_LATENCY);
    localparam logic [INJ_W-1:0]   INJ_LAST   = INJ_W'(INJ_PERIOD - 1);

    state_t             state_q;
    state_t             state_d;
    logic [RUN_W-1:0]   run_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [INJ_W-1:0]   inj_phase;
    logic [6:0]         prbs;
    logic               inj_en_q;
    logic               done_seen;

    logic busy;
    logic sending;
    logic start_go;
    logic run_last;
    logic drain_last;
    logic inj_hit;
    logic dl_tag;
    logic dl_bit;
    logic cmp_en;

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign sending    = (state_q == RUN);
    assign start_go   = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign run_last   = (run_cnt == RUN_LAST);
    assign drain_last = (drain_cnt == DRAIN_LAST);
    assign inj_hit    = busy && enc_valid_i && inj_en_q && (inj_phase == INJ_LAST);
    assign cmp_en     = busy && dl_tag;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: defaulting every comb output first is what keeps this block latch-free.
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i)    state_d = RUN;
            RUN:        if (run_last)   state_d = DRAIN;
            DRAIN:      if (drain_last) state_d = DONE;
            default:                    state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        enc_enable_o = sending;
        busy_o       = busy;
        done_o       = (state_q == DONE) && !done_seen;
        enc_bit_o    = sending & prbs[6];
        inj_mask_o   = inj_hit ? INJ_MASK_BIT0 : 2'b00;
    end

    // done_o pulses only on the first DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_seen <= 1'b0;
        end else begin
            done_seen <= (state_q == DONE);
        end
    end

    // ---------------- Sequencing: PRBS, run/drain length, injection phase ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prbs      <= PRBS_SEED;
            run_cnt   <= '0;
            drain_cnt <= '0;
            inj_phase <= '0;
            inj_en_q  <= 1'b0;
        end else if (start_go) begin
            prbs      <= PRBS_SEED;
            run_cnt   <= '0;
            drain_cnt <= '0;
            inj_phase <= '0;
            inj_en_q  <= inj_en_i;
        end else begin
            if (sending) begin
                prbs    <= prbs_next(prbs);
                run_cnt <= run_cnt + 1'b1;
            end
            if (state_q == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (busy && enc_valid_i) begin
                inj_phase <= (inj_phase == INJ_LAST) ? '0 : inj_phase + 1'b1;
            end
        end
    end

    // Matches the one-cycle channel register between encoder and decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_enable_o <= 1'b0;
        end else begin
            dec_enable_o <= enc_valid_i;
        end
    end

    // ---------------- Scoreboard ----------------
    link_delay_line #(
        .DEPTH (DEC_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_go),
        .shift   (busy),
        .tag_in  (sending),
        .bit_in  (enc_bit_o),
        .tag_out (dl_tag),
        .bit_out (dl_bit)
    );

    // Statistic counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt_o <= '0;
            bad_cnt_o  <= '0;
            inj_cnt_o  <= '0;
        end else if (start_go) begin
            good_cnt_o <= '0;
            bad_cnt_o  <= '0;
            inj_cnt_o  <= '0;
        end else begin
            if (inj_hit && (inj_cnt_o != '1)) begin
                inj_cnt_o <= inj_cnt_o + 1'b1;
            end
            if (cmp_en) begin
                if (dec_bit_i == dl_bit) begin
                    if (good_cnt_o != '1) good_cnt_o <= good_cnt_o + 1'b1;
                end else begin
                    if (bad_cnt_o != '1) bad_cnt_o <= bad_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Scoreboard bench for viterbi_link_ctrl: cycle driver pushes expectations, negedge monitor checks.
module tb_viterbi_link_ctrl;

    localparam int N_BITS      = 256;
    localparam int INJ_PERIOD  = 8;
    localparam int DEC_LATENCY = 32;
    localparam int CNT_W       = 16;
    localparam int DONE_CYC    = N_BITS + DEC_LATENCY + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             inj_en_i;
    logic             enc_enable_o;
    logic             enc_bit_o;
    logic             enc_valid_i;
    logic [1:0]       inj_mask_o;
    logic             dec_enable_o;
    logic             dec_bit_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] good_cnt_o;
    logic [CNT_W-1:0] bad_cnt_o;
    logic [CNT_W-1:0] inj_cnt_o;

    viterbi_link_ctrl #(
        .N_BITS      (N_BITS),
        .INJ_PERIOD  (INJ_PERIOD),
        .DEC_LATENCY (DEC_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .inj_en_i     (inj_en_i),
        .enc_enable_o (enc_enable_o),
        .enc_bit_o    (enc_bit_o),
        .enc_valid_i  (enc_valid_i),
        .inj_mask_o   (inj_mask_o),
        .dec_enable_o (dec_enable_o),
        .dec_bit_i    (dec_bit_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .good_cnt_o   (good_cnt_o),
        .bad_cnt_o    (bad_cnt_o),
        .inj_cnt_o    (inj_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] mask;
        logic       dec_en;
        logic       busy;
        logic       enc_en;
        logic       done;
    } cyc_exp_t;

    typedef struct {
        int good;
        int bad;
        int inj;
    } result_t;

    cyc_exp_t cyc_q[$];
    bit       bit_q[$];
    result_t  res_q[$];
    bit       ref_bits[N_BITS];
    logic     prev_valid;
    int       tests = 0;
    int       fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s at %0t", name, msg, $time);
    endtask

    task automatic check_counts(input string tag, input int good, input int bad, input int inj);
        check({tag, "_good"}, 32'(good_cnt_o), 32'(good));
        check({tag, "_bad"},  32'(bad_cnt_o),  32'(bad));
        check({tag, "_inj"},  32'(inj_cnt_o),  32'(inj));
    endtask

    // One clock cycle of stimulus; the expectation for this cycle goes to the monitor.
    task automatic cycle(input logic r, input logic st, input logic ie, input logic v,
                         input logic db, input cyc_exp_t e);
        @(posedge clk);
        #1;
        rst         = r;
        start_i     = st;
        inj_en_i    = ie;
        enc_valid_i = v;
        dec_bit_i   = db;
        e.dec_en    = r ? 1'b0 : prev_valid;
        prev_valid  = r ? 1'b0 : v;
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n);
        cyc_exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), e);
        end
    endtask

    // One run from IDLE/DONE. vmode 0: encoder valid exactly on enable cycles, else valid
    // percentage. abort_at >= 0 asserts reset at that RUN cycle (cycle 0 is the start cycle).
    task automatic run(input bit inj, input int flip_a, input int flip_b, input int vmode,
                       input bit poke, input int abort_at);
        logic     vv [0:DONE_CYC];
        int       nv;
        int       k;
        int       idx;
        int       nbits;
        result_t  r;
        cyc_exp_t e;
        logic     st;
        logic     db;

        nv = 0;
        for (int c = 0; c <= DONE_CYC; c++) begin
            if (vmode == 0) vv[c] = (c >= 1 && c <= N_BITS);
            else            vv[c] = ($urandom_range(99) < vmode);
            if (c >= 1 && c < DONE_CYC && vv[c]) nv++;
        end
        r.bad  = ((flip_a >= 0 && flip_a < N_BITS) ? 1 : 0) +
                 ((flip_b >= 0 && flip_b < N_BITS && flip_b != flip_a) ? 1 : 0);
        r.good = N_BITS - r.bad;
        r.inj  = inj ? nv / INJ_PERIOD : 0;

        nbits = (abort_at < 0) ? N_BITS : abort_at - 1;
        for (int i = 0; i < nbits; i++) bit_q.push_back(ref_bits[i]);
        if (abort_at < 0) res_q.push_back(r);

        k = 0;
        for (int c = 0; c <= DONE_CYC; c++) begin
            if (c == abort_at) begin
                e = '0;
                cycle(1'b1, 1'b0, 1'b0, vv[c], 1'b0, e);
                #1;
                check_counts("abort", 0, 0, 0);
                e = '0;
                cycle(1'b1, 1'b0, 1'b0, 1'($urandom), 1'b0, e);
                e = '0;
                cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0, e);
                idle(5);
                check("abort_bits_left", 32'(bit_q.size()), 32'd0);
                bit_q.delete();
                return;
            end
            e        = '0;
            e.enc_en = (c >= 1 && c <= N_BITS);
            e.busy   = (c >= 1 && c < DONE_CYC);
            e.done   = (c == DONE_CYC);
            if (e.busy && vv[c]) begin
                k++;
                if (inj && (k % INJ_PERIOD == 0)) e.mask = 2'b01;
            end
            idx = c - DEC_LATENCY - 1;
            if (idx >= 0 && idx < N_BITS) db = ref_bits[idx] ^ ((idx == flip_a) || (idx == flip_b));
            else                          db = 1'($urandom);
            st = (c == 0) || (poke && (c == N_BITS / 2 || c == N_BITS + DEC_LATENCY / 2));
            cycle(1'b0, st, (c == 0) ? inj : 1'($urandom), vv[c], db, e);
            if (c == 1) check_counts("cleared", 0, 0, 0);
        end
        idle(4);
        check_counts("held", r.good, r.bad, r.inj);
    endtask

    // Monitor: compares every cycle at the falling edge against the driver's expectations.
    cyc_exp_t mon_e;
    result_t  mon_r;
    bit       mon_bit;

    always @(negedge clk) begin
        if (cyc_q.size() != 0) begin
            mon_e = cyc_q.pop_front();
            check("enc_enable", 32'(enc_enable_o), 32'(mon_e.enc_en));
            check("busy",       32'(busy_o),       32'(mon_e.busy));
            check("done",       32'(done_o),       32'(mon_e.done));
            check("inj_mask",   32'(inj_mask_o),   32'(mon_e.mask));
            check("dec_enable", 32'(dec_enable_o), 32'(mon_e.dec_en));
            if (enc_enable_o === 1'b1) begin
                if (bit_q.size() == 0) begin
                    report_fail("enc_bit_extra", "source bit beyond expected stream");
                end else begin
                    mon_bit = bit_q.pop_front();
                    check("enc_bit", 32'(enc_bit_o), 32'(mon_bit));
                end
            end else begin
                check("enc_bit_idle", 32'(enc_bit_o), 32'd0);
            end
            if (done_o === 1'b1) begin
                if (res_q.size() == 0) begin
                    report_fail("done_extra", "done pulse with no run outstanding");
                end else begin
                    mon_r = res_q.pop_front();
                    check("res_good", 32'(good_cnt_o), 32'(mon_r.good));
                    check("res_bad",  32'(bad_cnt_o),  32'(mon_r.bad));
                    check("res_inj",  32'(inj_cnt_o),  32'(mon_r.inj));
                    check("res_sum",  32'(good_cnt_o) + 32'(bad_cnt_o), 32'(N_BITS));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_exp_t e;
        rst         = 1'b1;
        start_i     = 1'b0;
        inj_en_i    = 1'b0;
        enc_valid_i = 1'b0;
        dec_bit_i   = 1'b0;
        prev_valid  = 1'b0;

        // PRBS-7 output recurrence: o[n+7] = o[n] ^ o[n+1], seed all ones.
        for (int i = 0; i < 7; i++) ref_bits[i] = 1'b1;
        for (int i = 7; i < N_BITS; i++) ref_bits[i] = ref_bits[i-7] ^ ref_bits[i-6];

        for (int i = 0; i < 3; i++) begin
            e = '0;
            cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), e);
        end
        #1;
        check_counts("reset", 0, 0, 0);
        idle(20);
        check_counts("idle", 0, 0, 0);

        run(1'b0, -1, -1, 0, 1'b0, -1);      // clean loopback
        run(1'b1, -1, -1, 0, 1'b0, -1);      // injection, valid on every enable
        run(1'b0, 9, 199, 0, 1'b0, -1);      // two forced decoder errors
        run(1'b1, -1, -1, 0, 1'b1, -1);      // start poked mid-RUN and mid-DRAIN
        run(1'b1, -1, -1, 0, 1'b0, 100);     // reset at RUN cycle 100
        run(1'b0, -1, -1, 0, 1'b0, -1);      // clean run after abort
        for (int i = 0; i < 3; i++) begin
            run(1'($urandom), int'($urandom_range(N_BITS - 1)), int'($urandom_range(N_BITS + 20)),
                int'($urandom_range(30, 100)), 1'($urandom), -1);
        end

        idle(2);
        @(negedge clk);
        #1;
        check("pending_results", 32'(res_q.size()), 32'd0);
        check("pending_bits",    32'(bit_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
